// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and helpers for the register file with scoreboard
// Purpose: default widths, maximum read-port count and a byte-lane count helper.
// Ports: none (package).
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int MAX_RD     = 4;

    // Number of byte lanes in a data word; DATA_W is a multiple of 8.
    function automatic int byte_count(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending bits with alloc/clear/flush priority
// Purpose: tracks which registers await writeback.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   alloc_en, alloc_addr  set pending for a newly issued destination
//   clr_en, clr_addr      writeback clears pending for its register
//   flush                 clears every pending bit
//   rd_addr               packed read indices, port k at [k*ADDR_W +: ADDR_W]
//   rd_pend               stored pending bit per read port
//   any_pend              OR of all pending bits
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_addr,
    input  logic                     clr_en,
    input  logic [ADDR_W-1:0]        clr_addr,
    input  logic                     flush,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_pend,
    output logic                     any_pend
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pend_nxt;
    logic             alloc_ok;

    // Register 0 is never made pending, so its lookup is always 0.
    assign alloc_ok = alloc_en && !((ZERO_REG != 0) && (alloc_addr == '0));

    // Flush beats the writeback clear; a same-edge allocate is applied last
    // so the newest producer always wins.
    always_comb begin
        pend_nxt = pend;
        if (flush) begin
            pend_nxt = '0;
        end else if (clr_en) begin
            pend_nxt[clr_addr] = 1'b0;
        end
        if (alloc_ok) begin
            pend_nxt[alloc_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    assign any_pend = |pend;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_look
        assign rd_pend[k] = pend[rd_addr[k*ADDR_W +: ADDR_W]];
    end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-read-port register file with scoreboard and write-through bypass
// Purpose: register storage for the pipelined core; decode reads and allocates,
//          writeback writes with byte enables and clears pending state.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   rd_addr / rd_data     packed read indices / combinational read data per port
//   rd_pend               per-port pending flag, after bypass
//   alloc_en, alloc_addr  mark destination pending
//   wr_en, wr_addr, wr_be, wr_data   byte-enabled writeback
//   flush                 clear all pending bits
//   any_pend              OR of all pending bits
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pend,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_addr,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W/8-1:0]      wr_be,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     flush,
    output logic                     any_pend
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int NBYTES = byte_count(DATA_W);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [NUM_RD-1:0] sb_pend;
    logic              wr_ok;

    // Writes to the hardwired-zero register are dropped entirely.
    assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wr_be[b]) begin
                    regs[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk        (clk),
        .reset_n    (reset_n),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .clr_en     (wr_en),
        .clr_addr   (wr_addr),
        .flush      (flush),
        .rd_addr    (rd_addr),
        .rd_pend    (sb_pend),
        .any_pend   (any_pend)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              is_zero;
        logic              hit;
        logic              alloc_hit;
        logic [DATA_W-1:0] val;

        assign ra        = rd_addr[k*ADDR_W +: ADDR_W];
        assign is_zero   = (ZERO_REG != 0) && (ra == '0);
        // Reset gates the bypass so outputs read 0 while reset_n is low;
        // wr_ok already excludes register 0.
        assign hit       = (BYPASS != 0) && reset_n && wr_ok && (wr_addr == ra);
        assign alloc_hit = alloc_en && (alloc_addr == ra);

        always_comb begin
            val = is_zero ? '0 : regs[ra];
            if (hit) begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (wr_be[b]) begin
                        val[b*8 +: 8] = wr_data[b*8 +: 8];
                    end
                end
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = val;
        // A forwarded writeback is no longer pending unless a new producer
        // is allocated to the same register on the same edge.
        assign rd_pend[k] = hit ? alloc_hit : sb_pend[k];
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - self-checking bench for regfile_sb in three configurations
module tb_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_n;
    logic [3:0][4:0]  s_ra;
    logic             s_al_en;
    logic [4:0]       s_al_a;
    logic             s_wr_en;
    logic [4:0]       s_wr_a;
    logic [7:0]       s_be;
    logic [63:0]      s_wd;
    logic             s_fl;

    int checks = 0;
    int errors = 0;

    // Configs: 0 = 32b/5a/2rd bypass, 1 = 32b/5a/2rd no bypass, 2 = 64b/4a/4rd bypass
    logic [9:0]   ra_ab;
    logic [15:0]  ra_c;
    logic [63:0]  rd_data_a, rd_data_b;
    logic [255:0] rd_data_c;
    logic [1:0]   rd_pend_a, rd_pend_b;
    logic [3:0]   rd_pend_c;
    logic         any_a, any_b, any_c;

    assign ra_ab = {s_ra[1], s_ra[0]};
    assign ra_c  = {s_ra[3][3:0], s_ra[2][3:0], s_ra[1][3:0], s_ra[0][3:0]};

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .rd_addr(ra_ab), .rd_data(rd_data_a), .rd_pend(rd_pend_a),
        .alloc_en(s_al_en), .alloc_addr(s_al_a), .wr_en(s_wr_en), .wr_addr(s_wr_a),
        .wr_be(s_be[3:0]), .wr_data(s_wd[31:0]), .flush(s_fl), .any_pend(any_a));

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .rd_addr(ra_ab), .rd_data(rd_data_b), .rd_pend(rd_pend_b),
        .alloc_en(s_al_en), .alloc_addr(s_al_a), .wr_en(s_wr_en), .wr_addr(s_wr_a),
        .wr_be(s_be[3:0]), .wr_data(s_wd[31:0]), .flush(s_fl), .any_pend(any_b));

    regfile_sb #(.DATA_W(64), .ADDR_W(4), .NUM_RD(4), .ZERO_REG(1), .BYPASS(1)) dut_c (
        .clk(clk), .reset_n(reset_n), .rd_addr(ra_c), .rd_data(rd_data_c), .rd_pend(rd_pend_c),
        .alloc_en(s_al_en), .alloc_addr(s_al_a[3:0]), .wr_en(s_wr_en), .wr_addr(s_wr_a[3:0]),
        .wr_be(s_be), .wr_data(s_wd), .flush(s_fl), .any_pend(any_c));

    // Reference model: plain arrays of register values and pending flags.
    logic [63:0] m_reg  [3][32];
    bit          m_pend [3][32];

    function automatic int dw(input int c);  return (c == 2) ? 64 : 32; endfunction
    function automatic int nrd(input int c); return (c == 2) ? 4 : 2;   endfunction
    function automatic logic [4:0] amask(input int c, input logic [4:0] a);
        return (c == 2) ? {1'b0, a[3:0]} : a;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < 32; i++) begin
                m_reg[c][i]  = '0;
                m_pend[c][i] = 1'b0;
            end
    endtask

    task automatic model_expect(input int c, output logic [255:0] ed, output logic [3:0] ep,
                                output logic ea);
        logic [4:0]  a, wa, aa;
        logic [63:0] v;
        bit          p;
        ed = '0; ep = '0; ea = 1'b0;
        if (!reset_n) return;
        wa = amask(c, s_wr_a);
        aa = amask(c, s_al_a);
        for (int k = 0; k < nrd(c); k++) begin
            a = amask(c, s_ra[k]);
            v = '0; p = 1'b0;
            if (a != 0) begin
                v = m_reg[c][a];
                p = m_pend[c][a];
                if (c != 1 && s_wr_en && wa == a) begin
                    for (int b = 0; b < dw(c) / 8; b++)
                        if (s_be[b]) v[b*8 +: 8] = s_wd[b*8 +: 8];
                    p = s_al_en && (aa == a);
                end
            end
            ed = ed | (256'(v) << (k * dw(c)));
            ep[k] = p;
        end
        for (int i = 0; i < 32; i++) ea = ea | m_pend[c][i];
    endtask

    task automatic model_update();
        logic [4:0] wa, aa;
        if (!reset_n) begin
            model_reset();
            return;
        end
        for (int c = 0; c < 3; c++) begin
            wa = amask(c, s_wr_a);
            aa = amask(c, s_al_a);
            if (s_wr_en && wa != 0)
                for (int b = 0; b < dw(c) / 8; b++)
                    if (s_be[b]) m_reg[c][wa][b*8 +: 8] = s_wd[b*8 +: 8];
            if (s_fl) begin
                for (int i = 0; i < 32; i++) m_pend[c][i] = 1'b0;
            end else if (s_wr_en) begin
                m_pend[c][wa] = 1'b0;
            end
            if (s_al_en && aa != 0) m_pend[c][aa] = 1'b1;
        end
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        logic [255:0] ed, ad;
        logic [3:0]   ep, ap;
        logic         ea, aa;
        for (int c = 0; c < 3; c++) begin
            model_expect(c, ed, ep, ea);
            case (c)
                0:       begin ad = 256'(rd_data_a); ap = 4'(rd_pend_a); aa = any_a; end
                1:       begin ad = 256'(rd_data_b); ap = 4'(rd_pend_b); aa = any_b; end
                default: begin ad = rd_data_c;       ap = rd_pend_c;      aa = any_c; end
            endcase
            chk($sformatf("model_data_cfg%0d", c), ad, ed);
            chk($sformatf("model_pend_cfg%0d", c), 256'(ap), 256'(ep));
            chk($sformatf("model_any_cfg%0d", c), 256'(aa), 256'(ea));
        end
    endtask

    // Inputs are set just after a falling edge; this checks, clocks, and
    // returns positioned at the next falling edge.
    task automatic cycle();
        #1;
        check_model();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        s_ra = '0; s_al_en = 0; s_al_a = 0; s_wr_en = 0; s_wr_a = 0;
        s_be = 0; s_wd = 0; s_fl = 0;
    endtask

    typedef struct {
        bit          al_en; logic [4:0] al_a;
        bit          wr_en; logic [4:0] wr_a; logic [3:0] be; logic [31:0] wd;
        bit          fl;    logic [4:0] ra0;  logic [4:0] ra1;
        logic [31:0] d0b;   logic [31:0] d0n; logic [31:0] d1;
        bit          p0b;   bit p0n; bit p1; bit an;
    } vec_t;

    function automatic vec_t mk(bit al_en, logic [4:0] al_a, bit wr_en, logic [4:0] wr_a,
                                logic [3:0] be, logic [31:0] wd, bit fl,
                                logic [4:0] ra0, logic [4:0] ra1,
                                logic [31:0] d0b, logic [31:0] d0n, logic [31:0] d1,
                                bit p0b, bit p0n, bit p1, bit an);
        vec_t v;
        v.al_en = al_en; v.al_a = al_a; v.wr_en = wr_en; v.wr_a = wr_a; v.be = be; v.wd = wd;
        v.fl = fl; v.ra0 = ra0; v.ra1 = ra1; v.d0b = d0b; v.d0n = d0n; v.d1 = d1;
        v.p0b = p0b; v.p0n = p0n; v.p1 = p1; v.an = an;
        return v;
    endfunction

    vec_t tv[$];

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t actual=timeout required=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        //           al a   wr a  be    wd            fl ra0 ra1  d0 byp        d0 nobyp      d1            p0b p0n p1 any
        tv.push_back(mk(0, 0, 1, 5, 4'hF, 32'h0000_01F4, 0, 5, 0, 32'h0000_01F4, 32'h0,        32'h0,        0, 0, 0, 0));
        tv.push_back(mk(0, 0, 1, 0, 4'hF, 32'h7,         0, 5, 0, 32'h0000_01F4, 32'h0000_01F4,32'h0,        0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 4'h0, 32'h0,         0, 0, 5, 32'h0,         32'h0,        32'h0000_01F4,0, 0, 0, 0));
        tv.push_back(mk(0, 0, 1, 6, 4'hF, 32'hAABB_CCDD, 0, 6, 5, 32'hAABB_CCDD, 32'h0,        32'h0000_01F4,0, 0, 0, 0));
        tv.push_back(mk(0, 0, 1, 6, 4'h5, 32'h1122_3344, 0, 6, 5, 32'hAA22_CC44, 32'hAABB_CCDD,32'h0000_01F4,0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 4'h0, 32'h0,         0, 6, 5, 32'hAA22_CC44, 32'hAA22_CC44,32'h0000_01F4,0, 0, 0, 0));
        tv.push_back(mk(0, 0, 1, 7, 4'hF, 32'h1234,      0, 7, 6, 32'h1234,      32'h0,        32'hAA22_CC44,0, 0, 0, 0));
        tv.push_back(mk(1, 9, 0, 0, 4'h0, 32'h0,         0, 9, 7, 32'h0,         32'h0,        32'h1234,     0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 4'h0, 32'h0,         0, 9, 7, 32'h0,         32'h0,        32'h1234,     1, 1, 0, 1));
        tv.push_back(mk(0, 0, 1, 9, 4'hF, 32'h55,        0, 9, 7, 32'h55,        32'h0,        32'h1234,     0, 1, 0, 1));
        tv.push_back(mk(0, 0, 0, 0, 4'h0, 32'h0,         0, 9, 7, 32'h55,        32'h55,       32'h1234,     0, 0, 0, 0));
        tv.push_back(mk(1, 9, 1, 9, 4'hF, 32'h66,        0, 9, 7, 32'h66,        32'h55,       32'h1234,     1, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 4'h0, 32'h0,         0, 9, 7, 32'h66,        32'h66,       32'h1234,     1, 1, 0, 1));
        tv.push_back(mk(0, 0, 1, 9, 4'h0, 32'hFFFF_FFFF, 0, 9, 7, 32'h66,        32'h66,       32'h1234,     0, 1, 0, 1));
        tv.push_back(mk(0, 0, 0, 0, 4'h0, 32'h0,         0, 9, 7, 32'h66,        32'h66,       32'h1234,     0, 0, 0, 0));
        tv.push_back(mk(1, 3, 0, 0, 4'h0, 32'h0,         0, 3, 4, 32'h0,         32'h0,        32'h0,        0, 0, 0, 0));
        tv.push_back(mk(1, 4, 0, 0, 4'h0, 32'h0,         0, 3, 4, 32'h0,         32'h0,        32'h0,        1, 1, 0, 1));
        tv.push_back(mk(1, 8, 0, 0, 4'h0, 32'h0,         1, 3, 4, 32'h0,         32'h0,        32'h0,        1, 1, 1, 1));
        tv.push_back(mk(0, 0, 0, 0, 4'h0, 32'h0,         0, 8, 3, 32'h0,         32'h0,        32'h0,        1, 1, 0, 1));
        tv.push_back(mk(0, 0, 0, 0, 4'h0, 32'h0,         0, 4, 8, 32'h0,         32'h0,        32'h0,        0, 0, 1, 1));
        tv.push_back(mk(1, 0, 0, 0, 4'h0, 32'h0,         0, 0, 8, 32'h0,         32'h0,        32'h0,        0, 0, 1, 1));
        tv.push_back(mk(0, 0, 1, 8, 4'hF, 32'h99,        1, 8, 0, 32'h99,        32'h0,        32'h0,        0, 1, 0, 1));
        tv.push_back(mk(0, 0, 0, 0, 4'h0, 32'h0,         0, 8, 0, 32'h99,        32'h99,       32'h0,        0, 0, 0, 0));

        reset_n = 1'b0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        s_ra = {5'd3, 5'd2, 5'd1, 5'd5};
        #1;
        chk("reset_data_a", 256'(rd_data_a), '0);
        chk("reset_data_c", rd_data_c, '0);
        chk("reset_any_a", 256'(any_a), '0);
        @(negedge clk);

        for (int i = 0; i < tv.size(); i++) begin
            s_al_en = tv[i].al_en; s_al_a = tv[i].al_a;
            s_wr_en = tv[i].wr_en; s_wr_a = tv[i].wr_a;
            s_be = {4'h0, tv[i].be}; s_wd = {32'h0, tv[i].wd}; s_fl = tv[i].fl;
            s_ra = {5'd0, 5'd0, tv[i].ra1, tv[i].ra0};
            #1;
            chk($sformatf("v%0d_d0_a", i), 256'(rd_data_a[31:0]), 256'(tv[i].d0b));
            chk($sformatf("v%0d_d0_b", i), 256'(rd_data_b[31:0]), 256'(tv[i].d0n));
            chk($sformatf("v%0d_d0_c", i), 256'(rd_data_c[63:0]), 256'(tv[i].d0b));
            chk($sformatf("v%0d_d1_a", i), 256'(rd_data_a[63:32]), 256'(tv[i].d1));
            chk($sformatf("v%0d_d1_c", i), 256'(rd_data_c[127:64]), 256'(tv[i].d1));
            chk($sformatf("v%0d_p0_a", i), 256'(rd_pend_a[0]), 256'(tv[i].p0b));
            chk($sformatf("v%0d_p0_b", i), 256'(rd_pend_b[0]), 256'(tv[i].p0n));
            chk($sformatf("v%0d_p0_c", i), 256'(rd_pend_c[0]), 256'(tv[i].p0b));
            chk($sformatf("v%0d_p1_a", i), 256'(rd_pend_a[1]), 256'(tv[i].p1));
            chk($sformatf("v%0d_any_a", i), 256'(any_a), 256'(tv[i].an));
            chk($sformatf("v%0d_any_c", i), 256'(any_c), 256'(tv[i].an));
            cycle();
        end

        // Async reset with live registers and pending bits, checked before any edge.
        idle_inputs();
        s_al_en = 1; s_al_a = 5'd3;
        @(negedge clk);
        s_al_en = 0;
        s_ra = {5'd8, 5'd3, 5'd9, 5'd6};
        s_wr_en = 1; s_wr_a = 5'd6; s_be = 8'hFF; s_wd = 64'hDEAD_BEEF_CAFE_F00D;
        reset_n = 1'b0;
        #1;
        chk("async_rst_data_a", 256'(rd_data_a), '0);
        chk("async_rst_data_b", 256'(rd_data_b), '0);
        chk("async_rst_data_c", rd_data_c, '0);
        chk("async_rst_pend_a", 256'(rd_pend_a), '0);
        chk("async_rst_any_a", 256'(any_a), '0);
        chk("async_rst_any_c", 256'(any_c), '0);
        cycle();
        reset_n = 1'b1;
        idle_inputs();
        cycle();

        // Randomized traffic against the model, with occasional mid-run resets.
        for (int n = 0; n < 400; n++) begin
            reset_n = ($urandom_range(0, 49) != 0);
            for (int k = 0; k < 4; k++)
                s_ra[k] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            s_al_en = ($urandom_range(0, 2) == 0);
            s_al_a  = 5'($urandom_range(0, 7));
            s_wr_en = ($urandom_range(0, 1) == 0);
            s_wr_a  = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            s_be    = 8'($urandom);
            s_wd    = {$urandom, $urandom};
            s_fl    = ($urandom_range(0, 19) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
